fp_div_arbiter: RTL
===================

Name: fp_div_arbiter

Overview:
Shares one multi-cycle float_point_divide instance among N_REQ requesters. Round-robin arbitration with a valid/ready request handshake per requester. Sequences the divider's iValid/oDone protocol and returns each quotient to its owner over a held valid/ready response. Sits between the FP client ports and the divider: drives divider iA/iB/iValid and consumes oDone/oZ.

Parameters:
N_REQ, 4, number of requesters (2..8)
IDX_W, 2, width of grant index, equal to ceil(log2(N_REQ))
TIMEOUT_CYCLES, 64, watchdog limit in WAIT (used only with FPDIV_ARB_TIMEOUT_EN)

Ports:
clk  in  1  clock; all logic on posedge
reset  in  1  asynchronous, active-high reset
iReqValid  in  N_REQ  per-requester request valid
oReqReady  out  N_REQ  one-hot accept pulse
iReqA  in  N_REQ*32  dividends, requester k at bits [32k+31:32k]
iReqB  in  N_REQ*32  divisors, same packing
oRespValid  out  N_REQ  one-hot; held until matching iRespReady
iRespReady  in  N_REQ  per-requester response ready
oRespZ  out  32  quotient for the requester flagged in oRespValid
oRespErr  out  1  error qualifier, valid with oRespValid
oDivA  out  32  to divider iA
oDivB  out  32  to divider iB
oDivValid  out  1  to divider iValid; single-cycle pulse
iDivDone  in  1  from divider oDone
iDivZ  in  32  from divider oZ
oBusy  out  1  high in any state other than IDLE
oGrant  out  IDX_W  index of current owner; 0 in IDLE

Behaviour:
- Reset (asynchronous, any state): state=IDLE, rr pointer=0, all outputs 0, operand/result registers 0, stale flag 0. Reset mid-operation aborts the transaction silently; no response is issued.
- IDLE: if any iReqValid bit is set, grant the first set bit scanning from the rr pointer upward with wrap-around. Pulse oReqReady[g] for this one cycle. Latch iReqA/iReqB slice g. Register g into oGrant. Go to ISSUE. If no bit is set, remain in IDLE.
- ISSUE (1 cycle): oDivValid=1, and oDivA/oDivB carry the latched operands. Go to WAIT. oDivA/oDivB hold their value until the next grant.
- WAIT: when iDivDone=1, latch iDivZ and go to RESP. iDivDone arriving in IDLE, ISSUE or RESP is ignored.
- RESP: oRespValid[g]=1, and oRespZ/oRespErr are held stable. When iRespReady[g]=1 in the same cycle:
  - drop oRespValid;
  - set rr pointer = (g+1) mod N_REQ;
  - go to IDLE.
  iRespReady bits for other indices are ignored.
- Throughput: one division in flight at a time. Accept to oDivValid is 1 cycle. iDivDone to oRespValid is 1 cycle. RESP to the next accept is at least 1 cycle, because IDLE is always visited.
- Fairness: a requester holding iReqValid is granted within N_REQ transactions.
- A requester may drop iReqValid before being granted, with no side effect. Operands are sampled only in the grant cycle.
- oReqReady is never asserted outside IDLE. Requests arriving while busy wait.

Optional Feature:
Macro FPDIV_ARB_TIMEOUT_EN.
- With it defined:
  - A cycle counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without iDivDone, go to RESP with oRespErr=1 and oRespZ=32'h7FC00000 (qNaN), and set the stale flag.
  - While the stale flag is set, the first iDivDone seen in any state is discarded and clears the flag. If it arrives in WAIT, it is not taken as the current result.
  - A clean iDivDone in WAIT gives oRespErr=0.
- Without it: no counter and no stale flag; oRespErr is tied to 0; WAIT is unbounded.

Test Plan:
1. Single request, requester 0: A=0x3FC00000 (1.5), B=0x3F000000 (0.5) -> oReqReady[0] pulses, oDivValid one cycle later with the same operands, then oRespValid[0] with oRespZ=0x40400000 (3.0).
2. All four requesters valid in the same cycle with distinct operands, e.g. req2 A=0xC3D48000 (-425), B=0x41080000 (8.5) -> grants in order 0,1,2,3; req2 receives 0xC2480000 (-50); each oRespZ matches its owner.
3. Back-pressure: hold iRespReady[1]=0 for 10 cycles -> oRespValid[1] and oRespZ stay stable, no new grant occurs, and oReqReady stays 0 throughout.
4. Round-robin wrap: last grant 3, then requests on 0 and 3 -> grant 0 first; after that response, with both still requesting, grant 3 next.
5. Reset asserted during WAIT -> outputs go to 0 immediately with no clock edge; after release, a new request on requester 2 is served correctly and no response for the aborted job appears.
6. With FPDIV_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=64, iDivDone withheld -> oRespErr=1 and oRespZ=0x7FC00000 after 64 WAIT cycles; a late iDivDone is discarded; the next job returns its correct result with oRespErr=0.

Source files
------------

// File: rtl/fp_div_arbiter_if.sv
// fp_div_arbiter_if: requester handshakes, divider link and status of fp_div_arbiter.
// slave is the arbiter side; master is the client/divider side.
interface fp_div_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
);
    logic [N_REQ-1:0] iReqValid, oReqReady, oRespValid, iRespReady;
    logic [N_REQ*32-1:0] iReqA, iReqB;
    logic [31:0] oRespZ, oDivA, oDivB, iDivZ;
    logic oRespErr, oDivValid, iDivDone, oBusy;
    logic [IDX_W-1:0] oGrant;
    modport slave (
        input iReqValid, iReqA, iReqB, iRespReady, iDivDone, iDivZ,
        output oReqReady, oRespValid, oRespZ, oRespErr, oDivA, oDivB, oDivValid, oBusy, oGrant
    );
    modport master (
        output iReqValid, iReqA, iReqB, iRespReady, iDivDone, iDivZ,
        input oReqReady, oRespValid, oRespZ, oRespErr, oDivA, oDivB, oDivValid, oBusy, oGrant
    );
endinterface

// File: rtl/fp_div_arbiter.sv
// fp_div_arbiter: round-robin sharing of one multi-cycle FP divider among N_REQ requesters.
// Define FPDIV_ARB_TIMEOUT_EN to add a WAIT watchdog that answers with qNaN and oRespErr set.
module fp_div_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input logic clk,
    input logic reset,
    fp_div_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t state;
    logic [IDX_W-1:0] rrPtr, grantIdx, cand;
    logic found;
    if (N_REQ < 2 || N_REQ > 8 || IDX_W != $clog2(N_REQ) || TIMEOUT_CYCLES < 1) begin : badParams
        $error("fp_div_arbiter: unsupported parameter set");
    end
    // Descending scan so the last hit, i.e. the first set bit from rrPtr upward, wins.
    always_comb begin
        found = 1'b0;
        grantIdx = '0;
        cand = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = IDX_W'(int'(rrPtr) + k >= N_REQ ? int'(rrPtr) + k - N_REQ : int'(rrPtr) + k);
            if (bus.iReqValid[cand]) begin
                found = 1'b1;
                grantIdx = cand;
            end
        end
    end
    assign bus.oReqReady = (state == IDLE && found && !reset) ? N_REQ'(1) << grantIdx : '0;
    assign bus.oBusy = state != IDLE;
`ifdef FPDIV_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] cnt;
    logic stale;
`else
    assign bus.oRespErr = 1'b0;
`endif
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            rrPtr <= '0;
            bus.oGrant <= '0;
            bus.oDivA <= '0;
            bus.oDivB <= '0;
            bus.oDivValid <= 1'b0;
            bus.oRespValid <= '0;
            bus.oRespZ <= '0;
`ifdef FPDIV_ARB_TIMEOUT_EN
            bus.oRespErr <= 1'b0;
            cnt <= '0;
            stale <= 1'b0;
`endif
        end else begin
`ifdef FPDIV_ARB_TIMEOUT_EN
            // A late done from a timed-out job is swallowed wherever it lands.
            if (stale && bus.iDivDone) stale <= 1'b0;
`endif
            case (state)
                IDLE: if (found) begin
                    bus.oDivA <= bus.iReqA[{grantIdx, 5'd0} +: 32];
                    bus.oDivB <= bus.iReqB[{grantIdx, 5'd0} +: 32];
                    bus.oGrant <= grantIdx;
                    bus.oDivValid <= 1'b1;
                    state <= ISSUE;
                end
                ISSUE: begin
                    bus.oDivValid <= 1'b0;
`ifdef FPDIV_ARB_TIMEOUT_EN
                    cnt <= '0;
`endif
                    state <= WAIT;
                end
                WAIT: begin
`ifdef FPDIV_ARB_TIMEOUT_EN
                    cnt <= cnt + 1'b1;
                    if (bus.iDivDone && !stale) begin
                        bus.oRespZ <= bus.iDivZ;
                        bus.oRespErr <= 1'b0;
                        bus.oRespValid <= N_REQ'(1) << bus.oGrant;
                        state <= RESP;
                    end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        bus.oRespZ <= 32'h7FC0_0000;
                        bus.oRespErr <= 1'b1;
                        bus.oRespValid <= N_REQ'(1) << bus.oGrant;
                        stale <= 1'b1;
                        state <= RESP;
                    end
`else
                    if (bus.iDivDone) begin
                        bus.oRespZ <= bus.iDivZ;
                        bus.oRespValid <= N_REQ'(1) << bus.oGrant;
                        state <= RESP;
                    end
`endif
                end
                RESP: if (bus.iRespReady[bus.oGrant]) begin
                    bus.oRespValid <= '0;
                    rrPtr <= bus.oGrant == IDX_W'(N_REQ - 1) ? '0 : bus.oGrant + 1'b1;
                    bus.oGrant <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
